multicycle_control_unit: RTL
============================

// Module: multicycle_control_unit
// PURPOSE
//  Multi-cycle successor to the single-cycle MIPS control decoder: an FSM that sequences
//  fetch/decode/execute/memory/writeback over several cycles, with variable-latency memory
//  and divider handshakes. Sits between datapath (IR, PC, ALU, HI/LO, div unit) and unified memory.
//  Adds a retired-instruction counter, a divide watchdog and sticky illegal-opcode trapping.
// PARAMETERS
//  OPCODE_W     6    opcode field width
//  FUNCT_W      6    funct field width
//  ALUOP_W      4    ALU operation select width
//  DIV_TIMEOUT  64   max DIV_WAIT cycles before ERROR (>=2)
//  RETIRE_W     16   retired-instruction counter width (saturating)
// PORTS
//  clock        in   1         system clock, rising edge
//  reset_n      in   1         asynchronous active-low reset
//  opcode       in   OPCODE_W  IR[31:26] (valid from DECODE onward)
//  funct        in   FUNCT_W   IR[5:0]
//  mem_ready    in   1         memory completes current mem_req this cycle
//  div_done     in   1         divider result valid (HI/LO loaded) this cycle
//  mem_req      out  1         memory access request, held until mem_ready
//  mem_write    out  1         qualifies mem_req as store
//  iord         out  1         0: address=PC, 1: address=ALUOut
//  ir_write     out  1         load IR
//  pc_write     out  1         unconditional PC load
//  pc_write_br  out  1         PC load if branch condition true (bne on !zero)
//  pc_src       out  2         0 PC+4, 1 branch target, 2 jump target
//  alu_src_b    out  2         0 reg, 1 const 4, 2 sign-ext imm, 3 imm<<2
//  aluop        out  ALUOP_W   from mcu_alu_decode in EXEC; ADD in FETCH/MEM_ADDR; SUB in BRANCH
//  reg_write    out  1         register file write enable
//  reg_dst      out  1         0 rt, 1 rd
//  wb_sel       out  2         0 ALUOut, 1 MDR, 2 HI/LO
//  lo_or_hi     out  1         funct[1] in MF_WB, else 0
//  div_start    out  1         one-cycle pulse starting divider
//  illegal      out  1         sticky: unsupported opcode/funct or divide timeout
//  retired      out  RETIRE_W  instructions completed since reset, saturates at all-ones
// BEHAVIOUR
//  - Reset: state=FETCH, all outputs 0, retired=0, illegal=0, watchdog=0. Reset mid-access
//    drops mem_req immediately; no partial write is ever re-issued.
//  - All outputs Moore-decoded from registered state (plus opcode/funct latched in IR).
//  - FETCH: mem_req=1,iord=0,alu_src_b=1,aluop=ADD; hold until mem_ready; on ready
//    ir_write=1,pc_write=1,pc_src=0 same cycle -> DECODE.
//  - DECODE: alu_src_b=3 (precompute branch target). Dispatch on opcode:
//    0x00 funct 0x1A->DIV_START; 0x10/0x12->MF_WB; 0x00(sll),other legal R->EXEC_R;
//    0x08 addi,0x0A slti->EXEC_I; 0x23 lw,0x2B sw->MEM_ADDR; 0x05 bne->BRANCH;
//    0x02 j->JUMP; anything else->ERROR.
//  - EXEC_R->WB_ALU(reg_dst=1); EXEC_I (alu_src_b=2)->WB_ALU(reg_dst=0). WB_ALU: reg_write=1->FETCH.
//  - MEM_ADDR (alu_src_b=2,ADD)->MEM_RD (lw) or MEM_WR (sw). MEM_RD: mem_req,iord=1 until
//    mem_ready->WB_MEM (reg_write,wb_sel=1)->FETCH. MEM_WR: mem_req,mem_write,iord=1 until mem_ready->FETCH.
//  - BRANCH: aluop=SUB,pc_write_br=1,pc_src=1->FETCH. JUMP: pc_write=1,pc_src=2->FETCH.
//  - DIV_START: div_start=1 for exactly one cycle ->DIV_WAIT; no reg_write for div.
//    DIV_WAIT: watchdog counts from 1; div_done->FETCH; count reaches DIV_TIMEOUT without
//    div_done->ERROR. div_done on same cycle as timeout: done wins.
//  - MF_WB: reg_write=1,reg_dst=1,wb_sel=2,lo_or_hi=funct[1]->FETCH.
//  - ERROR: absorbing; illegal=1, all strobes 0; exit only via reset_n.
//  - retired increments on the cycle leaving any terminal state to FETCH (WB_ALU, WB_MEM,
//    MEM_WR done, BRANCH, JUMP, DIV_WAIT done, MF_WB); saturates, never wraps.
//  - mem_ready outside a mem_req state is ignored. CPI: R/I 4, lw 5+, sw 4+, branch/jump 3.
// STRUCTURE
//  - mcu_pkg: opcode/funct localparams, state enum (4-bit encoding), aluop codes, pc_src/wb_sel codes.
//  - Sub-module mcu_alu_decode: combinational opcode/funct -> aluop, instantiated once.
//  - Top: state register, next-state logic, output decode, watchdog and retired counters.
// TESTING
//  1 addi (op 0x08), mem_ready on first FETCH cycle -> states FETCH,DECODE,EXEC_I,WB_ALU; reg_write
//    1 cycle, reg_dst=0; retired=1.
//  2 lw (0x23), mem_ready delayed 3 cycles in both FETCH and MEM_RD -> mem_req held stable, iord
//    0 then 1, wb_sel=1 in WB_MEM; total 11 cycles.
//  3 div (op 0, funct 0x1A), div_done after 10 cycles -> single div_start pulse, FETCH next; then
//    mflo (funct 0x12) -> lo_or_hi=1, wb_sel=2; retired=2.
//  4 div with div_done never asserted, DIV_TIMEOUT=8 -> ERROR after 8 DIV_WAIT cycles, illegal=1
//    sticky, retired unchanged; reset_n low -> FETCH, illegal=0.
//  5 opcode 0x3F -> DECODE->ERROR; reset_n asserted mid MEM_WR (mem_req=1) -> mem_req=0 async.
//  6 RETIRE_W=4, 20 back-to-back j (0x02) -> retired saturates at 15; pc_src=2 each JUMP.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared encodings for the multi-cycle control unit: instruction fields,
// FSM state encoding and the datapath select/ALU operation codes.
package mcu_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_MFHI  = 6'h10;
    localparam logic [5:0] FN_MFLO  = 6'h12;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;

    localparam logic [1:0] PC_SRC_SEQ  = 2'd0;
    localparam logic [1:0] PC_SRC_BR   = 2'd1;
    localparam logic [1:0] PC_SRC_JMP  = 2'd2;

    localparam logic [1:0] SRCB_REG    = 2'd0;
    localparam logic [1:0] SRCB_FOUR   = 2'd1;
    localparam logic [1:0] SRCB_IMM    = 2'd2;
    localparam logic [1:0] SRCB_IMM_SH = 2'd3;

    localparam logic [1:0] WB_ALUOUT   = 2'd0;
    localparam logic [1:0] WB_MDR      = 2'd1;
    localparam logic [1:0] WB_HILO     = 2'd2;

    typedef enum logic [3:0] {
        ST_FETCH     = 4'd0,
        ST_DECODE    = 4'd1,
        ST_EXEC_R    = 4'd2,
        ST_EXEC_I    = 4'd3,
        ST_WB_ALU    = 4'd4,
        ST_MEM_ADDR  = 4'd5,
        ST_MEM_RD    = 4'd6,
        ST_MEM_WR    = 4'd7,
        ST_WB_MEM    = 4'd8,
        ST_BRANCH    = 4'd9,
        ST_JUMP      = 4'd10,
        ST_DIV_START = 4'd11,
        ST_DIV_WAIT  = 4'd12,
        ST_MF_WB     = 4'd13,
        ST_ERROR     = 4'd14
    } mcu_state_e;

endpackage

// File: rtl/mcu_alu_decode.sv
// Combinational ALU operation select for the EXEC states, plus a flag telling
// whether an R-type funct is one of the supported ALU operations.
module mcu_alu_decode
    import mcu_pkg::*;
#(
    parameter int OPCODE_W = 6,
    parameter int FUNCT_W  = 6,
    parameter int ALUOP_W  = 4
) (
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    output logic [ALUOP_W-1:0]  aluop,
    output logic                alu_r_legal
);

    // opcode/funct to ALU operation lookup
    always_comb begin
        aluop       = ALU_ADD;
        alu_r_legal = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                alu_r_legal = 1'b1;
                case (funct)
                    FN_SLL:           aluop = ALU_SLL;
                    FN_ADD, FN_ADDU:  aluop = ALU_ADD;
                    FN_SUB, FN_SUBU:  aluop = ALU_SUB;
                    FN_AND:           aluop = ALU_AND;
                    FN_OR:            aluop = ALU_OR;
                    FN_SLT:           aluop = ALU_SLT;
                    default: begin
                        aluop       = ALU_ADD;
                        alu_r_legal = 1'b0;
                    end
                endcase
            end
            OP_SLTI: aluop = ALU_SLT;
            default: aluop = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM with memory/divider handshakes, divide watchdog,
// sticky illegal trap and a saturating retired-instruction counter.
module multicycle_control_unit
    import mcu_pkg::*;
#(
    parameter int OPCODE_W    = 6,
    parameter int FUNCT_W     = 6,
    parameter int ALUOP_W     = 4,
    parameter int DIV_TIMEOUT = 64,
    parameter int RETIRE_W    = 16
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic [FUNCT_W-1:0]  funct,
    input  logic                mem_ready,
    input  logic                div_done,
    output logic                mem_req,
    output logic                mem_write,
    output logic                iord,
    output logic                ir_write,
    output logic                pc_write,
    output logic                pc_write_br,
    output logic [1:0]          pc_src,
    output logic [1:0]          alu_src_b,
    output logic [ALUOP_W-1:0]  aluop,
    output logic                reg_write,
    output logic                reg_dst,
    output logic [1:0]          wb_sel,
    output logic                lo_or_hi,
    output logic                div_start,
    output logic                illegal,
    output logic [RETIRE_W-1:0] retired
);

    localparam int WD_W = $clog2(DIV_TIMEOUT + 1);

    mcu_state_e          state_r;
    mcu_state_e          state_nxt_s;
    logic [WD_W-1:0]     wd_r;
    logic [ALUOP_W-1:0]  exec_aluop_s;
    logic                alu_r_legal_s;
    logic                retire_s;

    mcu_alu_decode #(
        .OPCODE_W (OPCODE_W),
        .FUNCT_W  (FUNCT_W),
        .ALUOP_W  (ALUOP_W)
    ) u_alu_decode (
        .opcode      (opcode),
        .funct       (funct),
        .aluop       (exec_aluop_s),
        .alu_r_legal (alu_r_legal_s)
    );

    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_FETCH;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // next-state logic and retirement strobe
    always_comb begin
        state_nxt_s = state_r;
        retire_s    = 1'b0;
        case (state_r)
            ST_FETCH: begin
                if (mem_ready) state_nxt_s = ST_DECODE;
                else           state_nxt_s = ST_FETCH;
            end
            ST_DECODE: begin
                case (opcode)
                    OP_RTYPE: begin
                        if (funct == FN_DIV)                          state_nxt_s = ST_DIV_START;
                        else if (funct == FN_MFHI || funct == FN_MFLO) state_nxt_s = ST_MF_WB;
                        else if (alu_r_legal_s)                        state_nxt_s = ST_EXEC_R;
                        else                                           state_nxt_s = ST_ERROR;
                    end
                    OP_ADDI, OP_SLTI: state_nxt_s = ST_EXEC_I;
                    OP_LW, OP_SW:     state_nxt_s = ST_MEM_ADDR;
                    OP_BNE:           state_nxt_s = ST_BRANCH;
                    OP_J:             state_nxt_s = ST_JUMP;
                    default:          state_nxt_s = ST_ERROR;
                endcase
            end
            ST_EXEC_R, ST_EXEC_I: state_nxt_s = ST_WB_ALU;
            ST_WB_ALU, ST_WB_MEM, ST_BRANCH, ST_JUMP, ST_MF_WB: begin
                state_nxt_s = ST_FETCH;
                retire_s    = 1'b1;
            end
            ST_MEM_ADDR: begin
                if (opcode == OP_SW) state_nxt_s = ST_MEM_WR;
                else                 state_nxt_s = ST_MEM_RD;
            end
            ST_MEM_RD: begin
                if (mem_ready) state_nxt_s = ST_WB_MEM;
                else           state_nxt_s = ST_MEM_RD;
            end
            ST_MEM_WR: begin
                if (mem_ready) begin
                    state_nxt_s = ST_FETCH;
                    retire_s    = 1'b1;
                end else begin
                    state_nxt_s = ST_MEM_WR;
                end
            end
            ST_DIV_START: state_nxt_s = ST_DIV_WAIT;
            ST_DIV_WAIT: begin
                // a completion arriving on the timeout cycle still counts as done
                if (div_done) begin
                    state_nxt_s = ST_FETCH;
                    retire_s    = 1'b1;
                end else if (wd_r >= WD_W'(DIV_TIMEOUT)) begin
                    state_nxt_s = ST_ERROR;
                end else begin
                    state_nxt_s = ST_DIV_WAIT;
                end
            end
            ST_ERROR: state_nxt_s = ST_ERROR;
            default:  state_nxt_s = ST_ERROR;
        endcase
    end

    // divide watchdog: holds the index of the current DIV_WAIT cycle (1-based)
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_r <= {WD_W{1'b0}};
        end else if (state_r == ST_DIV_START) begin
            wd_r <= {{(WD_W-1){1'b0}}, 1'b1};
        end else if (state_r == ST_DIV_WAIT && wd_r < WD_W'(DIV_TIMEOUT)) begin
            wd_r <= wd_r + {{(WD_W-1){1'b0}}, 1'b1};
        end else if (state_r != ST_DIV_WAIT) begin
            wd_r <= {WD_W{1'b0}};
        end
    end

    // saturating retired-instruction counter
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            retired <= {RETIRE_W{1'b0}};
        end else if (retire_s && retired != {RETIRE_W{1'b1}}) begin
            retired <= retired + {{(RETIRE_W-1){1'b0}}, 1'b1};
        end
    end

    // Moore output decode; everything is forced quiet while reset_n is low
    always_comb begin
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_write_br = 1'b0;
        pc_src      = PC_SRC_SEQ;
        alu_src_b   = SRCB_REG;
        aluop       = ALU_ADD;
        reg_write   = 1'b0;
        reg_dst     = 1'b0;
        wb_sel      = WB_ALUOUT;
        lo_or_hi    = 1'b0;
        div_start   = 1'b0;
        illegal     = 1'b0;
        if (reset_n) begin
            case (state_r)
                ST_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                ST_DECODE:   alu_src_b = SRCB_IMM_SH;
                ST_EXEC_R:   aluop     = exec_aluop_s;
                ST_EXEC_I: begin
                    alu_src_b = SRCB_IMM;
                    aluop     = exec_aluop_s;
                end
                ST_WB_ALU: begin
                    reg_write = 1'b1;
                    reg_dst   = (opcode == OP_RTYPE);
                end
                ST_MEM_ADDR: alu_src_b = SRCB_IMM;
                ST_MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                ST_MEM_WR: begin
                    mem_req   = 1'b1;
                    mem_write = 1'b1;
                    iord      = 1'b1;
                end
                ST_WB_MEM: begin
                    reg_write = 1'b1;
                    wb_sel    = WB_MDR;
                end
                ST_BRANCH: begin
                    aluop       = ALU_SUB;
                    pc_write_br = 1'b1;
                    pc_src      = PC_SRC_BR;
                end
                ST_JUMP: begin
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_JMP;
                end
                ST_DIV_START: div_start = 1'b1;
                ST_DIV_WAIT:  div_start = 1'b0;
                ST_MF_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    wb_sel    = WB_HILO;
                    lo_or_hi  = funct[1];
                end
                ST_ERROR: illegal = 1'b1;
                default:  illegal = 1'b1;
            endcase
        end else begin
            illegal = 1'b0;
        end
    end

endmodule
